// File: rtl/rnn_pkg.sv
// Shared types and constants for the RNN input feeder slice.
package rnn_pkg;

    localparam int RNN_X_W   = 32;
    localparam int RUN_CNT_W = 16;

    // Launch sequencing for one core run.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } launch_state_e;

    // Saturating +1 for the per-run pop counter.
    function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v);
        return (&v) ? v : v + RUN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/rnn_input_feeder_if.sv
// Host stream and core consume/launch signals of the input feeder.
interface rnn_input_feeder_if;
    import rnn_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic [RNN_X_W-1:0] s_data;
    logic               flush;
    logic               busy;
    logic               i_en;
    logic               ready;
    logic [RNN_X_W-1:0] idata;

    // Host + core side: supplies vectors, flush, busy and consume strobes.
    modport master (
        output s_valid, s_data, flush, busy, i_en,
        input  s_ready, ready, idata
    );

    // Feeder side.
    modport slave (
        input  s_valid, s_data, flush, busy, i_en,
        output s_ready, ready, idata
    );

endinterface

// File: rtl/rnn_sync_fifo.sv
// Single-clock FIFO with occupancy counter; head is read combinationally.
module rnn_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [AW:0]  level,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    // Flush wins over any same-cycle push or pop.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    // Empty reads as zero so the core never sees stale storage.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rnn_input_feeder.sv
// Buffers host input vectors, launches a core run and tracks it to completion.
module rnn_input_feeder
    import rnn_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int START_LEVEL = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    rnn_input_feeder_if.slave    bus,
    output logic [AW:0]          level,
    output logic                 underflow,
    output logic [RUN_CNT_W-1:0] run_pops,
    output logic                 run_done
);

    localparam logic [1:0]  S_IDLE    = 2'(ST_IDLE);
    localparam logic [1:0]  S_ARM     = 2'(ST_ARM);
    localparam logic [1:0]  S_RUN     = 2'(ST_RUN);
    localparam logic [1:0]  S_DONE    = 2'(ST_DONE);
    localparam logic [AW:0] START_LVL = (AW+1)'(START_LEVEL);

    logic [1:0] state;
    logic [1:0] state_n;
    logic       ready_q;
    logic       flush_eff;
    logic       arm_go;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;

    // Flush only counts between runs so an active run keeps its data.
    assign flush_eff = bus.flush && (state == S_IDLE);
    assign push      = bus.s_valid && !full;
    assign pop       = bus.i_en && !empty;
    assign arm_go    = (state == S_IDLE) && !flush_eff && (level >= START_LVL) && !bus.busy;

    assign bus.s_ready = !full;
    assign bus.ready   = ready_q;
    assign run_done    = (state == S_DONE);

    rnn_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (RNN_X_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush_eff),
        .wdata (bus.s_data),
        .rdata (bus.idata),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Launch sequencing: wait for data, hold ready until busy, wait for busy to fall.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (arm_go)    state_n = S_ARM;
            S_ARM:   if (bus.busy)  state_n = S_RUN;
            S_RUN:   if (!bus.busy) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered ready; ready is high for every ARM cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == S_ARM);
        end
    end

    // Sticky underflow, cleared by flush or a new launch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     underflow <= 1'b0;
        else if (flush_eff || arm_go)   underflow <= 1'b0;
        else if (bus.i_en && empty)     underflow <= 1'b1;
    end

    // Pops counted only while a run is armed or active; held after DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            run_pops <= '0;
        else if (arm_go)
            run_pops <= '0;
        else if (pop && (state == S_ARM || state == S_RUN))
            run_pops <= sat_inc(run_pops);
    end

endmodule

// File: doc/rnn_input_feeder.md
Name: rnn_input_feeder

Overview:
- Upstream stage of the RNN core: buffers 32-bit binary input vectors from a host stream in a FIFO and presents them on the core's idata/i_en consume interface.
- Launches each core run by driving ready, then tracks the run via busy until completion.
- Reports FIFO level, per-run pop count, underflow and run completion.

Parameters:
DEPTH, 16, FIFO entries (power of two, >=2)
AW, 4, log2(DEPTH); pointer width
START_LEVEL, 1, minimum buffered vectors (1..DEPTH) before a run is launched

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
s_valid  in  1  host vector valid
s_ready  out  1  feeder can accept a vector
s_data  in  32  host input vector; bit k = x[k]
flush  in  1  discard FIFO contents; honoured only in IDLE
busy  in  1  core busy
i_en  in  1  core consume strobe
ready  out  1  start request to core
idata  out  32  FIFO head vector to core
level  out  AW+1  current FIFO occupancy, 0..DEPTH
underflow  out  1  sticky: i_en seen while FIFO empty
run_pops  out  16  vectors consumed in current/last run
run_done  out  1  one-cycle pulse when a run ends

Behaviour:
- Reset (reset=0, asynchronous): pointers and level = 0, state IDLE, ready=0, underflow=0, run_pops=0, run_done=0. Storage contents are not reset.
- FIFO:
  - s_ready = (level != DEPTH), combinational.
  - Push when s_valid && s_ready; data is written at wr_ptr.
  - Pop on a rising edge where i_en=1 and level!=0.
  - idata = mem[rd_ptr] combinationally when level!=0, else 32'h0. The core samples idata on the same edge that i_en is high, so the head must be stable for the whole i_en cycle.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: level unchanged.
  - Push into an empty FIFO plus i_en in the same cycle: no pop, underflow is set, and the push completes.
  - Full FIFO with i_en: pop occurs; s_ready was low that cycle, so there is no push.
- i_en while empty: underflow <= 1 (sticky). Pointers and level are unchanged.
- Launch FSM, states IDLE, ARM, RUN, DONE:
  - IDLE: ready=0. Go to ARM when level >= START_LEVEL && busy=0. flush=1 in IDLE clears the pointers, level and underflow that cycle; flush has priority over a same-cycle push, which is dropped, and it blocks the ARM transition.
  - ARM: ready=1 (registered, asserted the cycle after entry). On entry clear run_pops and underflow. Stay until busy=1 is sampled, then go to RUN with ready=0. No timeout.
  - RUN: ready=0. Go to DONE when busy=0 is sampled.
  - DONE: run_done=1 for exactly one cycle, then IDLE.
  - flush outside IDLE is ignored.
- run_pops:
  - Increments on every successful pop in ARM or RUN.
  - Saturates at 16'hFFFF.
  - Holds its value from DONE until the next ARM entry.
  - Pops in IDLE (stray i_en) still pop the FIFO but are not counted.
- busy may rise in the same cycle ready first asserts plus one. The core latches ready into busy on its next edge, and the FSM must tolerate ready being high for only 1 cycle.
- Reset assertion mid-run: immediate return to IDLE, FIFO emptied, ready drops asynchronously.
- Width rules:
  - level is AW+1 bits so that DEPTH is representable.
  - Pointers are AW bits.
  - No arithmetic on the data path.

Decomposition:
- Shared package rnn_pkg: RNN_X_W=32, the launch state enum (IDLE/ARM/RUN/DONE), and RUN_CNT_W=16.
- One natural sub-module, rnn_sync_fifo (parameters DEPTH, AW, width 32).
  - Ports: push/pop/flush, head data, level, full/empty.
  - The top level holds the FSM, counters and flags.

Test Plan:
- Push 3 vectors 32'hA5A5_0001..0003 with START_LEVEL=1 -> ready rises 1 cycle after level>=1; model core busy=1 two cycles later -> ready drops, state RUN.
- Core pulses i_en 3 times in RUN -> idata equals 32'hA5A5_0001, 0002, 0003 on successive strobes; level 3->0; run_pops=3; busy falls -> run_done one-cycle pulse, run_pops holds 3.
- Fill 16 entries with no pops -> s_ready=0, level=16. Assert s_valid with i_en the same cycle -> pop only, level=15; next cycle s_ready=1.
- Empty FIFO, i_en=1 -> underflow=1, idata=0, level stays 0. Next ARM entry -> underflow cleared.
- Level=5 in IDLE with busy=1 held, flush=1 with s_valid=1 -> level=0, push dropped, no ARM. Same flush during RUN -> ignored, level unchanged.
- Drive reset=0 asynchronously mid-RUN with level=4 -> ready=0, level=0, run_pops=0 immediately without a clock edge; after release, state IDLE.
